spi_xfer_engine: RTL
====================

# spi_xfer_engine

- Byte-transfer engine of the APB SPI-lite master, directly downstream of the baud-rate generator.
- Consumes the generator's serial clock and sample pulse, and drives the generator's clock enable.
- Shifts one frame out on MOSI, captures one frame from MISO, and frames the transfer with an active-low slave select.
- The APB register block above it loads TX data, starts transfers, and reads RX data and the done pulse.

## Interface

- `DATA_W`, default 8: frame length in bits; legal range 4..16.
- `clk_i`, input, 1: system clock; all logic on its rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start_i`, input, 1: one-cycle transfer request; honoured only in IDLE.
- `abort_i`, input, 1: synchronous abort; overrides everything except reset.
- `cpha_i`, input, 1: clock phase; must be stable while `busy_o`=1.
- `lsbfe_i`, input, 1: LSB-first enable; present in all builds (see Configuration).
- `tx_data_i`, input, DATA_W: frame to send; sampled on the accepted `start_i`.
- `sclk_i`, input, 1: serial clock from the baud-rate generator.
- `sample_i`, input, 1: one-`clk_i` sample pulse from the baud-rate generator.
- `miso_i`, input, 1: serial data in; synchronised externally.
- `sclk_en_o`, output, 1: registered enable to the baud-rate generator.
- `ss_n_o`, output, 1: registered slave select, active low.
- `mosi_o`, output, 1: registered serial data out.
- `rx_data_o`, output, DATA_W: last completed received frame.
- `busy_o`, output, 1: high in any state other than IDLE.
- `done_o`, output, 1: one-cycle pulse when a frame completes.

## Operation

- **Edge detect.** `sclk_q` is `sclk_i` registered.
  - `edge = sclk_i ^ sclk_q`.
  - Sample edge = `edge & sample_i`.
  - Shift edge = `edge & ~sample_i`.
  - Edges are ignored in any state other than XFER.
- **FSM states:** IDLE, LEAD, XFER, TRAIL.
- **IDLE.**
  - Outputs: `ss_n_o`=1, `sclk_en_o`=0, `busy_o`=0.
  - On `start_i`: latch `tx_data_i` into `tx_sr`, clear `rx_sr` and `edge_cnt`, go to LEAD.
  - If `cpha_i`=0, also drive `mosi_o` with the first bit.
- **LEAD** (1 cycle).
  - `ss_n_o`=0, then go to XFER with `sclk_en_o`=1 registered.
  - This guarantees at least one `clk_i` cycle of slave-select setup before the first SCLK edge.
- **XFER.**
  - `edge_cnt` increments on every detected edge.
  - Sample edge: `rx_sr` shifts in `miso_i`.
  - Shift edge with CPHA=0: `mosi_o` advances to the next bit.
    - The final shift edge (edge 2·DATA_W) drives nothing new.
  - Shift edge with CPHA=1: `mosi_o` takes the next bit, starting with the first bit on edge 1.
  - Bit order: MSB first (`tx_sr[DATA_W-1]` out, `miso_i` into bit 0). LSB first when enabled and `lsbfe_i`=1.
  - On the edge that brings `edge_cnt` to 2·DATA_W: clear `sclk_en_o`, go to TRAIL.
- **TRAIL** (1 cycle).
  - `rx_data_o <= rx_sr`, `done_o`=1, `ss_n_o`=1, go to IDLE.
- **Abort.** In any state: go to IDLE, `sclk_en_o`=0, `ss_n_o`=1, `done_o`=0, `rx_data_o` unchanged.
- **Start while busy:** ignored and not queued.
- **Start and abort in the same cycle:** abort wins; stay in IDLE.
- **Widths.** `edge_cnt` is `$clog2(2*DATA_W+1)` bits and never wraps; it saturates at 2·DATA_W.

## Timing

- **Reset values:**
  - State IDLE.
  - `ss_n_o`=1, `sclk_en_o`=0, `mosi_o`=0, `busy_o`=0, `done_o`=0.
  - `rx_data_o`=0, `sclk_q`=0.
- **Start to outputs:**
  - `start_i` at cycle N.
  - `busy_o`=1 from cycle N+1.
  - `ss_n_o`=0 from cycle N+2.
  - `sclk_en_o`=1 from cycle N+3.
- **Edge response.** Each SCLK edge is seen one `clk_i` after the generator toggles SCLK. MOSI changes at most 1 `clk_i` after a shift edge.
- **Frame end.** The last edge at cycle M gives:
  - `sclk_en_o`=0 from M+1;
  - `done_o` and the `rx_data_o` update at M+2;
  - `ss_n_o`=1 from M+2.
- **Minimum divisor.** The generator's minimum divisor of 2 leaves exactly one spare cycle, so `sclk_en_o` falls before any further toggle. SCLK returns to idle polarity after an even edge count.
- **Back-to-back frames.** `start_i` in the `done_o` cycle is not accepted. The earliest accepted restart is the cycle after.

## Configuration

- **`SPI_LSBFE_EN` defined:** `lsbfe_i`=1 selects LSB-first for both TX and RX.
- **`SPI_LSBFE_EN` undefined:** `lsbfe_i` is ignored, always MSB-first, and the bit-order mux is not synthesised.

## Structure

- **Shared package `spi_pkg`:**
  - FSM state enum (IDLE/LEAD/XFER/TRAIL).
  - Default `DATA_W`.
  - Edge-count width function.
- **Sub-module `spi_shift_reg`:**
  - TX/RX shift pair with load, shift-out and shift-in strobes.
  - Optional bit-order mux.
- The FSM and edge detect stay in the top level.

## Test plan

1. **Mode 0, MSB first.** `tx_data_i`=0xA5, MISO pattern 0x3C, divisor 4.
   - MOSI shows 1,0,1,0,0,1,0,1 stable across each rising SCLK.
   - `rx_data_o`=0x3C.
   - One `done_o` pulse.
   - `ss_n_o` low for the full frame.
2. **Mode 3 (CPOL=1, CPHA=1), minimum divisor 2.** `tx_data_i`=0x81.
   - 16 edges seen.
   - First bit valid after the first falling edge.
   - `sclk_en_o` drops before a 17th toggle.
   - Received byte correct.
3. **LSB first with `SPI_LSBFE_EN`.** `lsbfe_i`=1, tx 0x01, MISO 0x80.
   - First MOSI bit 1.
   - `rx_data_o`=0x01.
   - Same stimulus without the macro: first bit 0, `rx_data_o`=0x80.
4. **Abort.** `abort_i` after edge 7.
   - IDLE next cycle.
   - `ss_n_o`=1, `sclk_en_o`=0.
   - No `done_o`.
   - `rx_data_o` still holds the previous 0x3C.
5. **Start handling.**
   - `start_i` while `busy_o`=1: ignored.
   - `start_i` in the cycle after `done_o`: new frame accepted, with `ss_n_o` high for ≥1 cycle between frames.
6. **Reset mid-frame.** `rst_n` low after edge 9.
   - All outputs take their reset values immediately and asynchronously.
   - After release, a new 0x5A frame completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-lite master transfer engine.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL
    } spi_state_e;

    localparam int unsigned SPI_DATA_W_DEF = 8;

    // Counter width able to hold 0..2*data_w SCLK edges.
    function automatic int unsigned edge_cnt_w(input int unsigned data_w);
        return $clog2(2 * data_w + 1);
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// TX/RX shift register pair of the SPI transfer engine.
// Optional bit-order mux enabled by macro SPI_LSBFE_EN.
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              pre_shift_i,
    input  logic              shift_out_i,
    input  logic              shift_in_i,
    input  logic              lsbfe_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              miso_i,
    output logic              first_bit_o,
    output logic              next_bit_o,
    output logic [DATA_W-1:0] rx_o
);

    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              lsb;

`ifdef SPI_LSBFE_EN
    assign lsb = lsbfe_i;
`else
    logic unused_lsbfe;
    assign unused_lsbfe = lsbfe_i;
    assign lsb          = 1'b0;
`endif

    assign first_bit_o = lsb ? data_i[0] : data_i[DATA_W-1];
    assign next_bit_o  = lsb ? tx_sr[0]  : tx_sr[DATA_W-1];
    assign rx_o        = rx_sr;

    // When the first bit is driven at load time (pre_shift) it is dropped from
    // tx_sr so that every later shift edge simply takes the register head.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr <= '0;
            rx_sr <= '0;
        end else if (load_i) begin
            if (pre_shift_i) begin
                tx_sr <= lsb ? (data_i >> 1) : (data_i << 1);
            end else begin
                tx_sr <= data_i;
            end
            rx_sr <= '0;
        end else begin
            if (shift_out_i) begin
                tx_sr <= lsb ? (tx_sr >> 1) : (tx_sr << 1);
            end
            if (shift_in_i) begin
                rx_sr <= lsb ? {miso_i, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso_i};
            end
        end
    end

endmodule

// File: rtl/spi_xfer_engine.sv
// Byte-transfer engine of the APB SPI-lite master: frames one transfer with
// slave select, shifts MOSI and captures MISO on baud-generator SCLK edges.
// Optional LSB-first support enabled by macro SPI_LSBFE_EN.
module spi_xfer_engine
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = SPI_DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              cpha_i,
    input  logic              lsbfe_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              sclk_i,
    input  logic              sample_i,
    input  logic              miso_i,
    output logic              sclk_en_o,
    output logic              ss_n_o,
    output logic              mosi_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned      CNT_W     = edge_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] EDGE_MAX  = CNT_W'(2 * DATA_W);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W - 1);

    spi_state_e        state, state_nxt;
    logic              sclk_q;
    logic [CNT_W-1:0]  edge_cnt, edge_cnt_nxt;
    logic              sclk_en_nxt, ss_n_nxt, mosi_nxt, done_nxt;
    logic [DATA_W-1:0] rx_nxt;
    logic              load, shift_out, shift_in;
    logic              first_bit, next_bit;
    logic [DATA_W-1:0] rx_sr;
    logic              sclk_edge, samp_edge, shft_edge, last_edge;

    assign sclk_edge = (sclk_i ^ sclk_q) & (state == XFER);
    assign samp_edge = sclk_edge & sample_i;
    assign shft_edge = sclk_edge & ~sample_i;
    assign last_edge = sclk_edge & (edge_cnt == LAST_EDGE);
    assign busy_o    = (state != IDLE);

    spi_shift_reg #(
        .DATA_W(DATA_W)
    ) u_shift_reg (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .load_i      (load),
        .pre_shift_i (~cpha_i),
        .shift_out_i (shift_out),
        .shift_in_i  (shift_in),
        .lsbfe_i     (lsbfe_i),
        .data_i      (tx_data_i),
        .miso_i      (miso_i),
        .first_bit_o (first_bit),
        .next_bit_o  (next_bit),
        .rx_o        (rx_sr)
    );

    // State, edge-detect and registered-output update.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sclk_q    <= 1'b0;
            edge_cnt  <= '0;
            sclk_en_o <= 1'b0;
            ss_n_o    <= 1'b1;
            mosi_o    <= 1'b0;
            done_o    <= 1'b0;
            rx_data_o <= '0;
        end else begin
            state     <= state_nxt;
            sclk_q    <= sclk_i;
            edge_cnt  <= edge_cnt_nxt;
            sclk_en_o <= sclk_en_nxt;
            ss_n_o    <= ss_n_nxt;
            mosi_o    <= mosi_nxt;
            done_o    <= done_nxt;
            rx_data_o <= rx_nxt;
        end
    end

    // Next-state and next-output decode; abort overrides every state.
    always_comb begin
        state_nxt    = state;
        edge_cnt_nxt = edge_cnt;
        sclk_en_nxt  = sclk_en_o;
        ss_n_nxt     = ss_n_o;
        mosi_nxt     = mosi_o;
        done_nxt     = 1'b0;
        rx_nxt       = rx_data_o;
        load         = 1'b0;
        shift_out    = 1'b0;
        shift_in     = 1'b0;
        if (abort_i) begin
            state_nxt   = IDLE;
            sclk_en_nxt = 1'b0;
            ss_n_nxt    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ss_n_nxt    = 1'b1;
                    sclk_en_nxt = 1'b0;
                    // done_o high means the previous frame closed this cycle.
                    if (start_i && !done_o) begin
                        load         = 1'b1;
                        edge_cnt_nxt = '0;
                        state_nxt    = LEAD;
                        if (!cpha_i) begin
                            mosi_nxt = first_bit;
                        end
                    end
                end
                LEAD: begin
                    ss_n_nxt  = 1'b0;
                    state_nxt = XFER;
                end
                XFER: begin
                    sclk_en_nxt = 1'b1;
                    if (sclk_edge) begin
                        if (edge_cnt != EDGE_MAX) begin
                            edge_cnt_nxt = edge_cnt + CNT_W'(1);
                        end
                        shift_in = samp_edge;
                        if (shft_edge && !last_edge) begin
                            shift_out = 1'b1;
                            mosi_nxt  = next_bit;
                        end
                        if (last_edge) begin
                            sclk_en_nxt = 1'b0;
                            state_nxt   = TRAIL;
                        end
                    end
                end
                TRAIL: begin
                    rx_nxt    = rx_sr;
                    done_nxt  = 1'b1;
                    ss_n_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
